fetch_addr_gen: RTL and testbench

// - Generates the 9-bit sequential fetch/step address that feeds the negedge 9-bit pipeline register (d input).
// - Updates on posedge clk, so addr is stable half a cycle before the downstream negedge capture.
// - Supports stall, branch redirect with a one-cycle bubble, wrap detection and an optional upper bound.

---
 rtl/fetch_addr_gen_if.sv | 26 ++
 rtl/fetch_addr_gen.sv | 123 ++++++++++++
 tb/tb_fetch_addr_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_addr_gen_if.sv
// fetch_addr_gen_if: fetch address generator handshake bundle.
//   slave  (generator):  in  en, stall, br_valid, br_target
//                        out addr, addr_valid, wrap, done
//   master (controller): opposite directions
interface fetch_addr_gen_if #(
  parameter int unsigned AW = 9
);
  logic          en;
  logic          stall;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          wrap;
  logic          done;

  modport slave (
    input  en, stall, br_valid, br_target,
    output addr, addr_valid, wrap, done
  );

  modport master (
    output en, stall, br_valid, br_target,
    input  addr, addr_valid, wrap, done
  );
endinterface

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: sequential fetch/step address generator feeding a
// negedge-captured pipeline register. Updates on posedge clk.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of fetch_addr_gen_if
//            en/stall/br_valid/br_target in; addr/addr_valid/wrap/done out
// Optional upper bound enabled by defining macro FETCH_BOUND_EN
// (adds DONE state at LIMIT); otherwise addr wraps mod 2^AW, done = 0.
module fetch_addr_gen #(
  parameter int unsigned   AW         = 9,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int unsigned   STEP       = 1,
  parameter logic [AW-1:0] LIMIT      = '1
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_addr_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic [AW:0]   sum;

`ifndef FETCH_BOUND_EN
  logic unused_limit;
  assign unused_limit = ^LIMIT;
`endif

  // Carry out of the widened sum is the wrap indication.
  assign sum = {1'b0, addr_q} + STEP_W;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          addr_d = bus.br_target;
        end else if (bus.en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.br_valid) begin
          addr_d  = bus.br_target;
          state_d = REDIR;
        end else if (!bus.en) begin
          state_d = IDLE;
        end else if (!bus.stall) begin
`ifdef FETCH_BOUND_EN
          if (addr_q == LIMIT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            addr_d = sum[AW-1:0];
            wrap_d = sum[AW];
          end
`else
          addr_d = sum[AW-1:0];
          wrap_d = sum[AW];
`endif
        end
      end
      REDIR: begin
        // Bubble cycle: stall is ignored, a new redirect extends it.
        if (bus.br_valid) begin
          addr_d = bus.br_target;
        end else begin
          state_d = bus.en ? RUN : IDLE;
        end
      end
`ifdef FETCH_BOUND_EN
      DONE: begin
        if (bus.br_valid) begin
          addr_d  = bus.br_target;
          state_d = REDIR;
        end else begin
          done_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Registered valid mirrors the state being entered.
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= RESET_ADDR;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_fetch_addr_gen.sv
// tb_fetch_addr_gen: self-checking bench for fetch_addr_gen (AW=9, STEP=1,
// LIMIT=0x010). Directed scenario tables plus randomized traffic checked
// against a behavioural model. Bound scenario runs when FETCH_BOUND_EN is set.
module tb_fetch_addr_gen;

  localparam int unsigned TB_STEP  = 1;
  localparam int unsigned TB_LIMIT = 16;
`ifdef FETCH_BOUND_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_addr_gen_if #(.AW(9)) bif ();

  fetch_addr_gen #(
    .AW         (9),
    .RESET_ADDR (9'h000),
    .STEP       (TB_STEP),
    .LIMIT      (9'h010)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {addr[8:0], addr_valid, wrap, done}.
  function automatic logic [11:0] obs();
    return {bif.addr, bif.addr_valid, bif.wrap, bif.done};
  endfunction

  task automatic cyc(input logic e, input logic s, input logic b, input logic [8:0] t);
    bif.en        = e;
    bif.stall     = s;
    bif.br_valid  = b;
    bif.br_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.en = 1'b0; bif.stall = 1'b0; bif.br_valid = 1'b0; bif.br_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table row: {en, stall, br_valid, br_target[8:0], expected obs[11:0]}
  task automatic test_reset();
    rst_n = 1'b0;
    bif.en = 1'b1; bif.stall = 1'b0; bif.br_valid = 1'b1; bif.br_target = 9'h0AB;
    #2;
    checks++;
    if (obs() !== {9'h000, 3'b000}) begin
      errors++;
      $display("FAIL reset_async got %h expected %h", obs(), {9'h000, 3'b000});
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== {9'h000, 3'b000}) begin
      errors++;
      $display("FAIL reset_held got %h expected %h", obs(), {9'h000, 3'b000});
    end
    do_reset();
  endtask

  task automatic test_sequential();
    logic [23:0] tbl [6];
    tbl = '{
      {3'b100, 9'h000, 9'h000, 3'b100},
      {3'b100, 9'h000, 9'h001, 3'b100},
      {3'b100, 9'h000, 9'h002, 3'b100},
      {3'b100, 9'h000, 9'h003, 3'b100},
      {3'b100, 9'h000, 9'h004, 3'b100},
      {3'b100, 9'h000, 9'h005, 3'b100}
    };
    foreach (tbl[i]) begin
      cyc(tbl[i][23], tbl[i][22], tbl[i][21], tbl[i][20:12]);
      checks++;
      if (obs() !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL seq[%0d] got %h expected %h", i, obs(), tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] tbl [4];
    tbl = '{
      {3'b110, 9'h000, 9'h005, 3'b100},
      {3'b110, 9'h000, 9'h005, 3'b100},
      {3'b110, 9'h000, 9'h005, 3'b100},
      {3'b100, 9'h000, 9'h006, 3'b100}
    };
    foreach (tbl[i]) begin
      cyc(tbl[i][23], tbl[i][22], tbl[i][21], tbl[i][20:12]);
      checks++;
      if (obs() !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL stall[%0d] got %h expected %h", i, obs(), tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_redirect();
    logic [23:0] tbl [6];
    tbl = '{
      {3'b111, 9'h1F0, 9'h1F0, 3'b000},  // redirect beats stall
      {3'b100, 9'h000, 9'h1F0, 3'b100},
      {3'b100, 9'h000, 9'h1F1, 3'b100},
      {3'b101, 9'h020, 9'h020, 3'b000},
      {3'b111, 9'h030, 9'h030, 3'b000},  // reload during bubble
      {3'b110, 9'h000, 9'h030, 3'b100}   // stall ignored in bubble
    };
    foreach (tbl[i]) begin
      cyc(tbl[i][23], tbl[i][22], tbl[i][21], tbl[i][20:12]);
      checks++;
      if (obs() !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL redir[%0d] got %h expected %h", i, obs(), tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] tbl [8];
    tbl = '{
      {3'b101, 9'h1FE, 9'h1FE, 3'b000},
      {3'b100, 9'h000, 9'h1FE, 3'b100},
      {3'b100, 9'h000, 9'h1FF, 3'b100},
      {3'b100, 9'h000, 9'h000, 3'b110},
      {3'b100, 9'h000, 9'h001, 3'b100},
      {3'b000, 9'h000, 9'h001, 3'b000},  // en low -> idle, addr held
      {3'b001, 9'h055, 9'h055, 3'b000},  // redirect in idle stays idle
      {3'b100, 9'h000, 9'h055, 3'b100}
    };
    foreach (tbl[i]) begin
      cyc(tbl[i][23], tbl[i][22], tbl[i][21], tbl[i][20:12]);
      checks++;
      if (obs() !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL wrap[%0d] got %h expected %h", i, obs(), tbl[i][11:0]);
      end
    end
  endtask

  task automatic test_reset_mid_redir();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 9'h000);
    cyc(1'b1, 1'b0, 1'b1, 9'h0AA);
    checks++;
    if (obs() !== {9'h0AA, 3'b000}) begin
      errors++;
      $display("FAIL midrst_redir got %h expected %h", obs(), {9'h0AA, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== {9'h000, 3'b000}) begin
      errors++;
      $display("FAIL midrst_async got %h expected %h", obs(), {9'h000, 3'b000});
    end
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 9'h000);
    checks++;
    if (obs() !== {9'h000, 3'b000}) begin
      errors++;
      $display("FAIL midrst_idle got %h expected %h", obs(), {9'h000, 3'b000});
    end
    cyc(1'b1, 1'b0, 1'b0, 9'h000);
    checks++;
    if (obs() !== {9'h000, 3'b100}) begin
      errors++;
      $display("FAIL midrst_run got %h expected %h", obs(), {9'h000, 3'b100});
    end
  endtask

  task automatic test_bound();
    logic [23:0] tbl [13];
    tbl = '{
      {3'b001, 9'h00E, 9'h00E, 3'b000},
      {3'b100, 9'h000, 9'h00E, 3'b100},
      {3'b100, 9'h000, 9'h00F, 3'b100},
      {3'b100, 9'h000, 9'h010, 3'b100},
      {3'b100, 9'h000, 9'h010, 3'b001},
      {3'b000, 9'h000, 9'h010, 3'b001},  // en low does not leave done
      {3'b101, 9'h000, 9'h000, 3'b000},
      {3'b100, 9'h000, 9'h000, 3'b100},
      {3'b100, 9'h000, 9'h001, 3'b100},
      {3'b101, 9'h010, 9'h010, 3'b000},
      {3'b110, 9'h000, 9'h010, 3'b100},
      {3'b110, 9'h000, 9'h010, 3'b100},  // stall at limit stays running
      {3'b100, 9'h000, 9'h010, 3'b001}
    };
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i][23], tbl[i][22], tbl[i][21], tbl[i][20:12]);
      checks++;
      if (obs() !== tbl[i][11:0]) begin
        errors++;
        $display("FAIL bound[%0d] got %h expected %h", i, obs(), tbl[i][11:0]);
      end
    end
  endtask

  // Behavioural reference: mode 0 idle, 1 running, 2 bubble, 3 bound reached.
  task automatic test_random();
    int          mode;
    int unsigned maddr;
    bit          mwrap;
    logic [11:0] expv;
    logic        e, s, b;
    logic [8:0]  t;
    do_reset();
    mode = 0; maddr = 0; mwrap = 0;
    for (int n = 0; n < 600; n++) begin
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       t = 9'($urandom_range(500, 511));
        1:       t = 9'($urandom_range(10, 16));
        default: t = 9'($urandom);
      endcase
      cyc(e, s, b, t);
      mwrap = 0;
      case (mode)
        0: if (b) maddr = t; else if (e) mode = 1;
        1: begin
          if (b) begin
            maddr = t; mode = 2;
          end else if (!e) begin
            mode = 0;
          end else if (!s) begin
            if (BOUND && maddr == TB_LIMIT) begin
              mode = 3;
            end else begin
              mwrap = (maddr + TB_STEP) >= 512;
              maddr = (maddr + TB_STEP) % 512;
            end
          end
        end
        2: if (b) maddr = t; else mode = e ? 1 : 0;
        default: if (b) begin maddr = t; mode = 2; end
      endcase
      expv = {9'(maddr), (mode == 1), mwrap, (mode == 3)};
      checks++;
      if (obs() !== expv) begin
        errors++;
        $display("FAIL rand[%0d] got %h expected %h", n, obs(), expv);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bif.en = 1'b0; bif.stall = 1'b0; bif.br_valid = 1'b0; bif.br_target = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_redir();
    if (BOUND) test_bound();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
